// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready register chain: per-slot stall, bubble collapse, per-slot kill and global flush.
// Slot 0 is the input end; slot STAGES-1 drives the output.
module pipe_reg_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_squash,
    output logic             o_ev,
    output logic             o_valid_nxt,
    output logic [WIDTH-1:0] o_data
);
    logic             r_v;
    logic [WIDTH-1:0] r_d;

    assign o_ev        = r_v & ~i_squash;
    assign o_valid_nxt = i_load ? i_in_valid : o_ev;
    assign o_data      = r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else begin
            r_v <= o_valid_nxt;
            // Empty slots keep stale data so bubbles cost no data toggling.
            if (i_load && i_in_valid)
                r_d <= i_in_data;
        end
    end
endmodule

module pipe_reg_chain #(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 4,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic [STAGES-1:0] kill,
    input  logic              flush,
    output logic [CW-1:0]     occupancy
);
    logic [STAGES-1:0]            w_ev;
    logic [STAGES-1:0]            w_vn;
    logic [STAGES-1:0]            w_rdy;
    logic [STAGES-1:0]            w_ld_v;
    logic [STAGES-1:0][WIDTH-1:0] w_ld_d;
    logic [STAGES-1:0][WIDTH-1:0] w_d;
    logic [CW-1:0]                w_occ_nxt;
    logic [CW-1:0]                r_occ;

    always_comb begin
        w_ld_v[0] = in_valid & ~flush;
        w_ld_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            w_ld_v[i] = w_ev[i-1];
            w_ld_d[i] = w_d[i-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_slot
            // Closed form of r[i] = ~ev[i] | r[i+1]: a slot is blocked only if it
            // and every slot ahead of it is live and the output is stalled.
            assign w_rdy[g] = out_ready | ~(&w_ev[STAGES-1:g]);

            pipe_reg_slot #(.WIDTH(WIDTH)) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_load     (w_rdy[g]),
                .i_in_valid (w_ld_v[g]),
                .i_in_data  (w_ld_d[g]),
                .i_squash   (kill[g] | flush),
                .o_ev       (w_ev[g]),
                .o_valid_nxt(w_vn[g]),
                .o_data     (w_d[g])
            );
        end
    endgenerate

    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < STAGES; i++)
            w_occ_nxt = w_occ_nxt + CW'(w_vn[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_occ <= '0;
        else        r_occ <= w_occ_nxt;
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign out_valid = w_ev[STAGES-1];
    assign out_data  = w_d[STAGES-1];
    assign occupancy = r_occ;
endmodule
